matrix_seq_ctrl: RTL and testbench

MATRIX_SEQ_CTRL -- requirements
Module: matrix_seq_ctrl

---
 rtl/matrix_seq_ctrl_pkg.sv | 41 ++++
 rtl/matrix_seq_ctrl_if.sv | 56 +++++
 rtl/matrix_seq_ctrl_tile_loader.sv | 95 +++++++++
 rtl/matrix_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_matrix_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_seq_ctrl_pkg.sv
// Shared sizing constants, mode encoding and controller state set for the
// matrix sequencing controller and its tile loader.
package matrix_seq_ctrl_pkg;

  localparam int ROW_W   = 264;
  localparam int HEIGHT  = 32;
  localparam int TILE    = 16;
  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 1024;

  typedef enum logic [1:0] {
    MODE_INT8    = 2'd0,
    MODE_INT4    = 2'd1,
    MODE_VSQ     = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_A    = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  function automatic logic mode_legal(input logic [1:0] mode);
    return mode != MODE_ILLEGAL;
  endfunction

  // Returned as {is_vsq, is_int4_mode, is_int8_mode}.
  function automatic logic [2:0] mode_onehot(input logic [1:0] mode);
    logic [2:0] oh;
    case (mode)
      MODE_INT8: oh = 3'b001;
      MODE_INT4: oh = 3'b010;
      MODE_VSQ:  oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/matrix_seq_ctrl_if.sv
// Bundle of the controller's host, SRAM and accelerator signals; the host /
// memory side uses the master modport, the controller uses the slave modport.
interface matrix_seq_ctrl_if
  import matrix_seq_ctrl_pkg::*;
#(
  parameter int ROW_W  = matrix_seq_ctrl_pkg::ROW_W,
  parameter int TILE   = matrix_seq_ctrl_pkg::TILE,
  parameter int ADDR_W = matrix_seq_ctrl_pkg::ADDR_W
);

  logic                    start;
  logic [1:0]              cfg_mode;
  logic [7:0]              cfg_scale;
  logic [7:0]              cfg_bias;

  logic                    a_sram_ren;
  logic                    b_sram_ren;
  logic [ADDR_W-1:0]       a_sram_addr;
  logic [ADDR_W-1:0]       b_sram_addr;
  logic [ROW_W-1:0]        a_sram_rdata;
  logic [ROW_W-1:0]        b_sram_rdata;

  logic [TILE*ROW_W-1:0]   a_vec;
  logic [ROW_W-1:0]        b_vec;
  logic                    valid_mac;
  logic                    valid_ppu;
  logic                    is_int8_mode;
  logic                    is_int4_mode;
  logic                    is_vsq;
  logic [7:0]              scale;
  logic [7:0]              bias;

  logic                    acc_done;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output start, cfg_mode, cfg_scale, cfg_bias,
    output a_sram_rdata, b_sram_rdata, acc_done,
    input  a_sram_ren, b_sram_ren, a_sram_addr, b_sram_addr,
    input  a_vec, b_vec, valid_mac, valid_ppu,
    input  is_int8_mode, is_int4_mode, is_vsq, scale, bias,
    input  busy, done, err
  );

  modport slave (
    input  start, cfg_mode, cfg_scale, cfg_bias,
    input  a_sram_rdata, b_sram_rdata, acc_done,
    output a_sram_ren, b_sram_ren, a_sram_addr, b_sram_addr,
    output a_vec, b_vec, valid_mac, valid_ppu,
    output is_int8_mode, is_int4_mode, is_vsq, scale, bias,
    output busy, done, err
  );

endinterface

// File: rtl/matrix_seq_ctrl_tile_loader.sv
// A-operand loader: reads all HEIGHT A rows back to back, packs rows 0..TILE-1
// into the active tile and the rest into a shadow tile, swapped in on request.
module seq_tile_loader
  import matrix_seq_ctrl_pkg::*;
#(
  parameter int ROW_W  = matrix_seq_ctrl_pkg::ROW_W,
  parameter int HEIGHT = matrix_seq_ctrl_pkg::HEIGHT,
  parameter int TILE   = matrix_seq_ctrl_pkg::TILE,
  parameter int ADDR_W = matrix_seq_ctrl_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load_start,
  input  logic                  swap,
  input  logic [ROW_W-1:0]      a_rdata,
  output logic                  a_ren,
  output logic [ADDR_W-1:0]     a_addr,
  output logic [TILE*ROW_W-1:0] a_vec
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);

  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_row_q, pend_row_d;

  always_comb begin
    ren_d      = ren_q;
    cnt_d      = cnt_q;
    pend_d     = ren_q;
    pend_row_d = cnt_q;
    if (load_start) begin
      ren_d = 1'b1;
      cnt_d = '0;
    end else if (ren_q) begin
      // Stop after the last row so the address never runs past the operand.
      if (cnt_q == LAST_ROW) begin
        ren_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ren_q      <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_row_q <= '0;
    end else begin
      ren_q      <= ren_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
    end
  end

  assign a_ren  = ren_q;
  assign a_addr = cnt_q;

  // Slot gi holds row gi (active) or row gi+TILE (shadow); slot 0 is the MSB.
  for (genvar gi = 0; gi < TILE; gi++) begin : g_row
    logic [ROW_W-1:0] act_q, act_d;
    logic [ROW_W-1:0] shd_q, shd_d;

    always_comb begin
      act_d = act_q;
      shd_d = shd_q;
      if (swap) begin
        act_d = shd_q;
      end else if (pend_q && (pend_row_q == ADDR_W'(gi))) begin
        act_d = a_rdata;
      end
      if (pend_q && (pend_row_q == ADDR_W'(gi + TILE))) begin
        shd_d = a_rdata;
      end
    end

    always_ff @(posedge clk) begin
      if (srst) begin
        act_q <= '0;
        shd_q <= '0;
      end else begin
        act_q <= act_d;
        shd_q <= shd_d;
      end
    end

    assign a_vec[TILE*ROW_W-1-gi*ROW_W -: ROW_W] = act_q;
  end

endmodule

// File: rtl/matrix_seq_ctrl.sv
// Sequencer feeding a matrix accelerator: loads an A tile, streams B rows with
// the A tile swapped halfway, then waits for the accelerator to finish.
module matrix_seq_ctrl
  import matrix_seq_ctrl_pkg::*;
#(
  parameter int ROW_W   = matrix_seq_ctrl_pkg::ROW_W,
  parameter int HEIGHT  = matrix_seq_ctrl_pkg::HEIGHT,
  parameter int TILE    = matrix_seq_ctrl_pkg::TILE,
  parameter int ADDR_W  = matrix_seq_ctrl_pkg::ADDR_W,
  parameter int TIMEOUT = matrix_seq_ctrl_pkg::TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  matrix_seq_ctrl_if.slave bus
);

  localparam int                TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic              b_ren_q, b_ren_d;
  logic              b_pend_q, b_pend_d;
  logic [ROW_W-1:0]  b_vec_q, b_vec_d;
  logic              valid_mac_q, valid_mac_d;
  logic              valid_ppu_q, valid_ppu_d;
  logic [2:0]        mode_oh_q, mode_oh_d;
  logic [7:0]        scale_q, scale_d;
  logic [7:0]        bias_q, bias_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic                  load_start;
  logic                  swap;
  logic                  a_ren;
  logic [ADDR_W-1:0]     a_addr;
  logic [TILE*ROW_W-1:0] a_vec;

  seq_tile_loader #(
    .ROW_W  (ROW_W),
    .HEIGHT (HEIGHT),
    .TILE   (TILE),
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk        (clk),
    .srst       (rst),
    .load_start (load_start),
    .swap       (swap),
    .a_rdata    (bus.a_sram_rdata),
    .a_ren      (a_ren),
    .a_addr     (a_addr),
    .a_vec      (a_vec)
  );

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    b_ren_d     = b_ren_q;
    b_pend_d    = b_ren_q;
    b_vec_d     = b_pend_q ? bus.b_sram_rdata : b_vec_q;
    valid_mac_d = b_pend_q;
    valid_ppu_d = valid_ppu_q;
    mode_oh_d   = mode_oh_q;
    scale_d     = scale_q;
    bias_d      = bias_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    to_d        = to_q;
    load_start  = 1'b0;
    swap        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (mode_legal(bus.cfg_mode)) begin
            state_d    = ST_LOAD_A;
            load_start = 1'b1;
            mode_oh_d  = mode_onehot(bus.cfg_mode);
            scale_d    = bus.cfg_scale;
            bias_d     = bus.cfg_bias;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD_A: begin
        // The loader keeps reading A rows TILE.. during STREAM on its own.
        if (a_ren && (a_addr == ADDR_W'(TILE - 1))) begin
          state_d = ST_STREAM;
          b_ren_d = 1'b1;
          c_d     = '0;
        end
      end

      ST_STREAM: begin
        if (b_pend_q && (c_q == ADDR_W'(1))) begin
          valid_ppu_d = 1'b1;
        end
        // Data for B row TILE arrives while c has moved to TILE+1.
        swap = b_pend_q && (c_q == ADDR_W'(TILE + 1));
        if (b_ren_q) begin
          if (c_q == LAST_ROW) begin
            b_ren_d = 1'b0;
          end else begin
            c_d = c_q + 1'b1;
          end
        end else begin
          // Last read issued; this edge loads the final B row.
          state_d = ST_WAIT_DONE;
          c_d     = '0;
          to_d    = '0;
        end
      end

      ST_WAIT_DONE: begin
        if (bus.acc_done) begin
          done_d      = 1'b1;
          valid_ppu_d = 1'b0;
          state_d     = ST_IDLE;
          to_d        = '0;
        end else if (to_q == TO_LAST) begin
          err_d       = 1'b1;
          valid_ppu_d = 1'b0;
          state_d     = ST_IDLE;
          to_d        = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      c_q         <= '0;
      b_ren_q     <= 1'b0;
      b_pend_q    <= 1'b0;
      b_vec_q     <= '0;
      valid_mac_q <= 1'b0;
      valid_ppu_q <= 1'b0;
      mode_oh_q   <= '0;
      scale_q     <= '0;
      bias_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      b_ren_q     <= b_ren_d;
      b_pend_q    <= b_pend_d;
      b_vec_q     <= b_vec_d;
      valid_mac_q <= valid_mac_d;
      valid_ppu_q <= valid_ppu_d;
      mode_oh_q   <= mode_oh_d;
      scale_q     <= scale_d;
      bias_q      <= bias_d;
      done_q      <= done_d;
      err_q       <= err_d;
      to_q        <= to_d;
    end
  end

  assign bus.a_sram_ren   = a_ren;
  assign bus.a_sram_addr  = a_addr;
  assign bus.b_sram_ren   = b_ren_q;
  assign bus.b_sram_addr  = c_q;
  assign bus.a_vec        = a_vec;
  assign bus.b_vec        = b_vec_q;
  assign bus.valid_mac    = valid_mac_q;
  assign bus.valid_ppu    = valid_ppu_q;
  assign bus.is_int8_mode = mode_oh_q[0];
  assign bus.is_int4_mode = mode_oh_q[1];
  assign bus.is_vsq       = mode_oh_q[2];
  assign bus.scale        = scale_q;
  assign bus.bias         = bias_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Scoreboard bench for matrix_seq_ctrl: directed runs push expected SRAM reads,
// MAC beats and done/err events; a negedge monitor pops and compares them.
module tb_matrix_seq_ctrl;
  import matrix_seq_ctrl_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] v0;
    logic [7:0] v1;
    logic [7:0] v2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t exp_mac[$];
  exp_t exp_evt[$];

  logic [ROW_W-1:0] a_mem [HEIGHT];
  logic [ROW_W-1:0] b_mem [HEIGHT];

  matrix_seq_ctrl_if bus ();

  matrix_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (bus.a_sram_ren) bus.a_sram_rdata <= a_mem[bus.a_sram_addr];
    if (bus.b_sram_ren) bus.b_sram_rdata <= b_mem[bus.b_sram_addr];
  end

  function automatic exp_t mk(input int c, input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
    exp_t e;
    e.cyc = c;
    e.v0  = x0;
    e.v1  = x1;
    e.v2  = x2;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc=%0d)", name, act, want, cyc);
    end else begin
      $display("txn %s ok value=%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] zero_vec();
    return {44'd0,
            bus.a_sram_ren, bus.b_sram_ren, bus.valid_mac, bus.valid_ppu,
            bus.busy, bus.done, bus.err,
            bus.is_int8_mode, bus.is_int4_mode, bus.is_vsq,
            |bus.scale, |bus.bias, |bus.a_vec, |bus.b_vec,
            |bus.a_sram_addr, |bus.b_sram_addr, 4'd0};
  endfunction

  // Monitor: every DUT-presented transaction must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] ab0, ab15, bb0, kind;
    if (bus.a_sram_ren) begin
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL a_read: unexpected addr=%0d cyc=%0d", bus.a_sram_addr, cyc);
      end else begin
        e = exp_a.pop_front();
        if (8'(bus.a_sram_addr) !== e.v0 || cyc != e.cyc) begin
          bad++;
          $display("FAIL a_read: got addr=%0d cyc=%0d want addr=%0d cyc=%0d", bus.a_sram_addr, cyc, e.v0, e.cyc);
        end else $display("txn a_read addr=%0d cyc=%0d ok", e.v0, cyc);
      end
    end
    if (bus.b_sram_ren) begin
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL b_read: unexpected addr=%0d cyc=%0d", bus.b_sram_addr, cyc);
      end else begin
        e = exp_b.pop_front();
        if (8'(bus.b_sram_addr) !== e.v0 || cyc != e.cyc) begin
          bad++;
          $display("FAIL b_read: got addr=%0d cyc=%0d want addr=%0d cyc=%0d", bus.b_sram_addr, cyc, e.v0, e.cyc);
        end else $display("txn b_read addr=%0d cyc=%0d ok", e.v0, cyc);
      end
    end
    if (bus.valid_mac) begin
      total++;
      bb0  = bus.b_vec[7:0];
      ab0  = bus.a_vec[(TILE-1)*ROW_W +: 8];
      ab15 = bus.a_vec[7:0];
      if (exp_mac.size() == 0) begin
        bad++;
        $display("FAIL mac: unexpected beat b=%0d cyc=%0d", bb0, cyc);
      end else begin
        e = exp_mac.pop_front();
        if (bb0 !== e.v0 || ab0 !== e.v1 || ab15 !== e.v2 || cyc != e.cyc || bus.valid_ppu !== 1'b1) begin
          bad++;
          $display("FAIL mac: got b=%0d a0=%0d a15=%0d ppu=%0b cyc=%0d want b=%0d a0=%0d a15=%0d ppu=1 cyc=%0d",
                   bb0, ab0, ab15, bus.valid_ppu, cyc, e.v0, e.v1, e.v2, e.cyc);
        end else $display("txn mac b=%0d a0=%0d a15=%0d cyc=%0d ok", bb0, ab0, ab15, cyc);
      end
    end
    if (bus.done || bus.err) begin
      total++;
      kind = {6'd0, bus.done, bus.err};
      if (exp_evt.size() == 0) begin
        bad++;
        $display("FAIL event: unexpected done=%0b err=%0b cyc=%0d", bus.done, bus.err, cyc);
      end else begin
        e = exp_evt.pop_front();
        if (kind !== e.v0 || cyc != e.cyc || bus.busy !== 1'b0 || bus.valid_ppu !== 1'b0) begin
          bad++;
          $display("FAIL event: got kind=%0d cyc=%0d busy=%0b ppu=%0b want kind=%0d cyc=%0d busy=0 ppu=0",
                   kind, cyc, bus.busy, bus.valid_ppu, e.v0, e.cyc);
        end else $display("txn event kind=%0d cyc=%0d ok", kind, cyc);
      end
    end
  end

  // One accepted run. done_w: cycle within WAIT_DONE to pulse acc_done (-1 none).
  // abort_k: cycle after accept at which rst is applied (-1 none).
  task automatic run_seq(input logic [1:0] mode, input logic [7:0] sc, input logic [7:0] bi,
                         input int done_w, input int abort_k);
    int t0, n_b, n_mac, end_k, k;
    logic [2:0] oh;
    t0    = cyc + 1;
    oh    = 3'b001 << mode;
    n_b   = (abort_k < 0) ? HEIGHT : abort_k - TILE + 1;
    n_mac = (abort_k < 0) ? HEIGHT : abort_k - 18 + 1;
    end_k = (done_w >= 0) ? 49 + done_w + 1 : 49 + TIMEOUT;
    for (int i = 0; i < HEIGHT; i++) exp_a.push_back(mk(t0 + i, 8'(i), 8'd0, 8'd0));
    for (int i = 0; i < n_b; i++) exp_b.push_back(mk(t0 + TILE + i, 8'(i), 8'd0, 8'd0));
    for (int i = 0; i < n_mac; i++)
      exp_mac.push_back(mk(t0 + 18 + i, 8'(i), (i < TILE) ? 8'd0 : 8'(TILE),
                           (i < TILE) ? 8'(TILE - 1) : 8'(HEIGHT - 1)));
    if (abort_k < 0) begin
      if (done_w >= 0) exp_evt.push_back(mk(t0 + end_k, 8'd2, 8'd0, 8'd0));
      else             exp_evt.push_back(mk(t0 + end_k, 8'd1, 8'd0, 8'd0));
    end
    bus.start     = 1'b1;
    bus.cfg_mode  = mode;
    bus.cfg_scale = sc;
    bus.cfg_bias  = bi;
    tick();
    bus.start     = 1'b0;
    bus.cfg_mode  = 2'd3;
    bus.cfg_scale = 8'hee;
    bus.cfg_bias  = 8'h00;
    check("cfg_latch", {37'd0, bus.busy, bus.is_vsq, bus.is_int4_mode, bus.is_int8_mode, bus.scale, bus.bias},
          {37'd0, 1'b1, oh, sc, bi});
    k = 0;
    while (1) begin
      if (k == 21) begin
        bus.start    = 1'b1;
        bus.cfg_mode = 2'd2;
        bus.acc_done = 1'b1;
      end
      if (k == 22) begin
        bus.start    = 1'b0;
        bus.cfg_mode = 2'd3;
        bus.acc_done = 1'b0;
      end
      if (k == abort_k) begin
        rst = 1'b1;
        tick();
        check("abort_zero", zero_vec(), 64'd0);
        rst = 1'b0;
        tick();
        return;
      end
      if (k == 53) check("wait_ppu_busy", {62'd0, bus.valid_ppu, bus.busy}, 64'd3);
      if (done_w >= 0 && k == 49 + done_w) bus.acc_done = 1'b1;
      if (done_w >= 0 && k == 49 + done_w + 1) bus.acc_done = 1'b0;
      if (k == end_k) break;
      tick();
      k++;
    end
    tick();
    check("post_idle", {37'd0, bus.busy, bus.valid_ppu, bus.done, bus.err, 3'd0, bus.scale, bus.bias},
          {37'd0, 4'd0, 3'd0, sc, bi});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int r = 0; r < HEIGHT; r++) begin
      a_mem[r] = {8'(8'h40 + r), {(ROW_W-16){1'b0}}, 8'(r)};
      b_mem[r] = {8'(8'h80 + r), {(ROW_W-16){1'b0}}, 8'(r)};
    end
    bus.start     = 1'b0;
    bus.cfg_mode  = 2'd0;
    bus.cfg_scale = 8'd0;
    bus.cfg_bias  = 8'd0;
    bus.acc_done  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_zero", zero_vec(), 64'd0);
    rst = 1'b0;
    tick();

    run_seq(2'd0, 8'h65, 8'h01, 5, -1);

    t0 = cyc + 1;
    exp_evt.push_back(mk(t0, 8'd1, 8'd0, 8'd0));
    bus.start    = 1'b1;
    bus.cfg_mode = 2'd3;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("illegal_hold", {37'd0, bus.busy, bus.is_vsq, bus.is_int4_mode, bus.is_int8_mode, bus.scale, bus.bias},
          {37'd0, 1'b0, 3'b001, 8'h65, 8'h01});

    run_seq(2'd1, 8'h3c, 8'h7f, -1, -1);
    check("timeout_mode", {61'd0, bus.is_vsq, bus.is_int4_mode, bus.is_int8_mode}, 64'd2);

    run_seq(2'd2, 8'h11, 8'h22, -1, 36);

    run_seq(2'd0, 8'h65, 8'h01, 5, -1);

    repeat (4) tick();
    check("queues_empty", 64'(exp_a.size() + exp_b.size() + exp_mac.size() + exp_evt.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
